// File: rtl/geo_pkg.sv
// Shared types and widths for the pixel-writer block: coordinate, address and data sizes,
// plus the write-entry payload carried through the FIFO.
package geo_pkg;

  localparam int unsigned ADDR_W  = 20;
  localparam int unsigned COORD_W = 12;
  localparam int unsigned DATA_W  = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } pix_wr_t;

endpackage

// File: rtl/geo_pixel_writer_if.sv
// Memory write port of the pixel writer: request with address/data, acknowledged by memory.
interface geo_pixel_writer_if;
  import geo_pkg::*;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
  modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);

endinterface

// File: rtl/geo_wr_fifo.sv
// Synchronous FIFO of pixel write entries; head is zeroed while empty so the bus idles at 0.
module geo_wr_fifo
  import geo_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  pix_wr_t                push_data_i,
  input  logic                   pop_i,
  output pix_wr_t                head_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  pix_wr_t             mem_q [Depth];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]       count_q, count_d;
  logic                push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO is allowed when the head leaves in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && ((count_q < (PtrW+1)'(Depth)) || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/geo_pixel_writer.sv
// Turns line-generator pixels into frame-buffer byte writes: clip and multiply (S1),
// address add (S2), then a FIFO feeding the memory write port.
module geo_pixel_writer
  import geo_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      cfg_load,
  input  logic [ADDR_W-1:0]         cfg_base,
  input  logic [11:0]               cfg_stride,
  input  logic [11:0]               cfg_clip_w,
  input  logic [11:0]               cfg_clip_h,
  input  logic [DATA_W-1:0]         cfg_color,
  input  logic                      pix_valid,
  input  logic signed [COORD_W-1:0] pix_x,
  input  logic signed [COORD_W-1:0] pix_y,
  output logic                      pause,
  geo_pixel_writer_if.master        wr,
  output logic                      idle,
  output logic [15:0]               clip_cnt
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_W-1:0]  base_q, base_d;
  logic [11:0]        stride_q, stride_d, clip_w_q, clip_w_d, clip_h_q, clip_h_d;
  logic [DATA_W-1:0]  color_q, color_d;

  // S1 keeps a snapshot of base/stride/color so a later cfg_load cannot alter it.
  logic               s1_valid_q, s1_valid_d;
  logic [COORD_W-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic [ADDR_W-1:0]  s1_base_q, s1_base_d;
  logic [11:0]        s1_stride_q, s1_stride_d;
  logic [DATA_W-1:0]  s1_color_q, s1_color_d;

  logic               s2_valid_q, s2_valid_d;
  logic [23:0]        s2_prod_q, s2_prod_d;
  logic [COORD_W-1:0] s2_x_q, s2_x_d;
  logic [ADDR_W-1:0]  s2_base_q, s2_base_d;
  logic [DATA_W-1:0]  s2_color_q, s2_color_d;

  logic [15:0]        clip_cnt_q, clip_cnt_d;

  logic [CntW-1:0]    fifo_count;
  logic [CntW:0]      occupancy;
  logic               fifo_empty, accept, s1_clip, push, pop;
  logic [23:0]        s1_prod;
  pix_wr_t            push_data, head;

  assign occupancy = {1'b0, fifo_count} + {{CntW{1'b0}}, s1_valid_q}
                   + {{CntW{1'b0}}, s2_valid_q};
  assign pause     = (occupancy >= (CntW+1)'(FIFO_DEPTH));
  assign accept    = enable && pix_valid && !pause;
  assign idle      = !s1_valid_q && !s2_valid_q && (fifo_count == '0);
  assign clip_cnt  = clip_cnt_q;

  // Sign bit catches negatives; non-negative coordinates compare as plain unsigned.
  assign s1_clip = s1_x_q[COORD_W-1] || s1_y_q[COORD_W-1] ||
                   (s1_x_q >= clip_w_q) || (s1_y_q >= clip_h_q);
  assign s1_prod = 24'(s1_y_q) * 24'(s1_stride_q);

  assign push           = enable && s2_valid_q;
  assign push_data.addr = s2_base_q + s2_prod_q[ADDR_W-1:0] + ADDR_W'(s2_x_q);
  assign push_data.data = s2_color_q;
  assign pop            = enable && wr.wr_req && wr.wr_ack;

  assign wr.wr_req  = !fifo_empty;
  assign wr.wr_addr = head.addr;
  assign wr.wr_data = head.data;

  always_comb begin
    base_d      = base_q;
    stride_d    = stride_q;
    clip_w_d    = clip_w_q;
    clip_h_d    = clip_h_q;
    color_d     = color_q;
    s1_valid_d  = s1_valid_q;
    s1_x_d      = s1_x_q;
    s1_y_d      = s1_y_q;
    s1_base_d   = s1_base_q;
    s1_stride_d = s1_stride_q;
    s1_color_d  = s1_color_q;
    s2_valid_d  = s2_valid_q;
    s2_prod_d   = s2_prod_q;
    s2_x_d      = s2_x_q;
    s2_base_d   = s2_base_q;
    s2_color_d  = s2_color_q;
    clip_cnt_d  = clip_cnt_q;
    if (enable) begin
      if (cfg_load) begin
        base_d   = cfg_base;
        stride_d = cfg_stride;
        clip_w_d = cfg_clip_w;
        clip_h_d = cfg_clip_h;
        color_d  = cfg_color;
      end
      s1_valid_d = accept;
      if (accept) begin
        s1_x_d      = pix_x;
        s1_y_d      = pix_y;
        s1_base_d   = base_q;
        s1_stride_d = stride_q;
        s1_color_d  = color_q;
      end
      s2_valid_d = s1_valid_q && !s1_clip;
      if (s1_valid_q) begin
        s2_prod_d  = s1_prod;
        s2_x_d     = s1_x_q;
        s2_base_d  = s1_base_q;
        s2_color_d = s1_color_q;
      end
      if (s1_valid_q && s1_clip && (clip_cnt_q != 16'hFFFF)) clip_cnt_d = clip_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q      <= '0;
      stride_q    <= '0;
      clip_w_q    <= '0;
      clip_h_q    <= '0;
      color_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_base_q   <= '0;
      s1_stride_q <= '0;
      s1_color_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_prod_q   <= '0;
      s2_x_q      <= '0;
      s2_base_q   <= '0;
      s2_color_q  <= '0;
      clip_cnt_q  <= '0;
    end else begin
      base_q      <= base_d;
      stride_q    <= stride_d;
      clip_w_q    <= clip_w_d;
      clip_h_q    <= clip_h_d;
      color_q     <= color_d;
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s1_base_q   <= s1_base_d;
      s1_stride_q <= s1_stride_d;
      s1_color_q  <= s1_color_d;
      s2_valid_q  <= s2_valid_d;
      s2_prod_q   <= s2_prod_d;
      s2_x_q      <= s2_x_d;
      s2_base_q   <= s2_base_d;
      s2_color_q  <= s2_color_d;
      clip_cnt_q  <= clip_cnt_d;
    end
  end

  geo_wr_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_geo_pixel_writer.sv
// Directed bench for geo_pixel_writer: inputs change on the falling edge, outputs are
// checked on the falling edge, expected values are hand-computed constants.
module tb_geo_pixel_writer;
  import geo_pkg::*;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               enable = 1'b0;
  logic               cfg_load = 1'b0;
  logic [ADDR_W-1:0]  cfg_base = '0;
  logic [11:0]        cfg_stride = '0, cfg_clip_w = '0, cfg_clip_h = '0;
  logic [DATA_W-1:0]  cfg_color = '0;
  logic               pix_valid = 1'b0;
  logic signed [11:0] pix_x = '0, pix_y = '0;
  logic               pause, idle;
  logic [15:0]        clip_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc;
  int n_req;

  geo_pixel_writer_if wr_if ();

  geo_pixel_writer #(
    .FIFO_DEPTH (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .cfg_load   (cfg_load),
    .cfg_base   (cfg_base),
    .cfg_stride (cfg_stride),
    .cfg_clip_w (cfg_clip_w),
    .cfg_clip_h (cfg_clip_h),
    .cfg_color  (cfg_color),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pause      (pause),
    .wr         (wr_if.master),
    .idle       (idle),
    .clip_cnt   (clip_cnt)
  );

  always #4 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic configure(input logic [19:0] b, input logic [11:0] s, input logic [11:0] w,
                           input logic [11:0] h, input logic [7:0] c);
    cfg_base = b; cfg_stride = s; cfg_clip_w = w; cfg_clip_h = h; cfg_color = c;
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic send_pixel(input int x, input int y);
    pix_x = 12'(x); pix_y = 12'(y); pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_if.wr_ack = 1'b0;
    #3;
    check_eq("rst_pause", pause, 0);
    check_eq("rst_req", wr_if.wr_req, 0);
    check_eq("rst_idle", idle, 1);
    check_eq("rst_addr", wr_if.wr_addr, 0);
    check_eq("rst_data", wr_if.wr_data, 0);
    check_eq("rst_clip", clip_cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;
    enable  = 1'b1;
    @(negedge clk);

    // Single pixel, 3-cycle latency
    configure(20'h01000, 12'd640, 12'd640, 12'd480, 8'h5A);
    wr_if.wr_ack = 1'b1;
    send_pixel(3, 2);
    check_eq("lat_c1_req", wr_if.wr_req, 0);
    @(negedge clk);
    check_eq("lat_c2_req", wr_if.wr_req, 0);
    @(negedge clk);
    check_eq("lat_c3_req", wr_if.wr_req, 1);
    check_eq("lat_addr", wr_if.wr_addr, 32'h01503);
    check_eq("lat_data", wr_if.wr_data, 32'h5A);
    @(negedge clk);
    check_eq("lat_single", wr_if.wr_req, 0);
    check_eq("lat_idle", idle, 1);

    // Clipped pixels
    pix_x = -12'sd1; pix_y = 12'sd5; pix_valid = 1'b1;
    @(negedge clk);
    pix_x = 12'sd640; pix_y = 12'sd0;
    @(negedge clk);
    pix_x = 12'sd0; pix_y = 12'sd480;
    @(negedge clk);
    pix_valid = 1'b0;
    n_req = 0;
    for (int i = 0; i < 5; i++) begin
      if (wr_if.wr_req) n_req++;
      @(negedge clk);
    end
    check_eq("clip_no_req", n_req, 0);
    check_eq("clip_cnt", clip_cnt, 3);
    check_eq("clip_idle", idle, 1);

    // Last visible pixel is written
    send_pixel(639, 479);
    @(negedge clk);
    @(negedge clk);
    check_eq("edge_req", wr_if.wr_req, 1);
    check_eq("edge_addr", wr_if.wr_addr, 32'h4BFFF);
    @(negedge clk);

    // Enable low: pixel not accepted
    enable = 1'b0; pix_x = 12'sd1; pix_y = 12'sd1; pix_valid = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge clk);
    check_eq("en_hold_idle", idle, 1);
    pix_valid = 1'b0; enable = 1'b1;
    @(negedge clk);

    // Backpressure: ack held low, continuous stream
    wr_if.wr_ack = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 14; i++) begin
      pix_x = 12'(n_acc); pix_y = 12'sd1; pix_valid = 1'b1;
      if (!pause) n_acc++;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    check_eq("bp_accepts", n_acc, 8);
    check_eq("bp_pause", pause, 1);
    check_eq("bp_req", wr_if.wr_req, 1);
    wr_if.wr_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("bp_addr%0d", i), {wr_if.wr_req, wr_if.wr_addr},
               {1'b1, 20'h01280 + 20'(i)});
      @(negedge clk);
    end
    check_eq("bp_drained", wr_if.wr_req, 0);
    check_eq("bp_pause_off", pause, 0);

    // Address wrap
    configure(20'hFFFF0, 12'd0, 12'd640, 12'd480, 8'h5A);
    wr_if.wr_ack = 1'b0;
    send_pixel(32, 0);
    @(negedge clk);
    @(negedge clk);
    check_eq("wrap_req", wr_if.wr_req, 1);
    check_eq("wrap_addr", wr_if.wr_addr, 32'h00010);
    wr_if.wr_ack = 1'b1;
    @(negedge clk);
    check_eq("wrap_pop", wr_if.wr_req, 0);

    // Reset with queued entries
    configure(20'h01000, 12'd640, 12'd640, 12'd480, 8'h5A);
    wr_if.wr_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pix_x = 12'(i); pix_y = 12'sd0; pix_valid = 1'b1;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("q5_req", wr_if.wr_req, 1);
    check_eq("q5_idle", idle, 0);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_req", wr_if.wr_req, 0);
    check_eq("mid_rst_idle", idle, 1);
    check_eq("mid_rst_clip", clip_cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;
    wr_if.wr_ack = 1'b1;
    n_req = 0;
    for (int i = 0; i < 6; i++) begin
      if (wr_if.wr_req) n_req++;
      @(negedge clk);
    end
    check_eq("post_rst_stale", n_req, 0);

    // Color change right after an accept
    configure(20'h01000, 12'd640, 12'd640, 12'd480, 8'h5A);
    wr_if.wr_ack = 1'b0;
    pix_x = 12'sd3; pix_y = 12'sd2; pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0; cfg_color = 8'h11; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0; pix_x = 12'sd4; pix_y = 12'sd2; pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    check_eq("col_a_addr", wr_if.wr_addr, 32'h01503);
    check_eq("col_a_data", wr_if.wr_data, 32'h5A);
    wr_if.wr_ack = 1'b1;
    @(negedge clk);
    check_eq("col_b_addr", wr_if.wr_addr, 32'h01504);
    check_eq("col_b_data", wr_if.wr_data, 32'h11);
    @(negedge clk);
    check_eq("col_done", wr_if.wr_req, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/geo_pixel_writer.md
GEO_PIXEL_WRITER -- requirements
Module: geo_pixel_writer

Interface
REQ-001 clk  input  1  125 MHz pixel clock; one clock domain; all logic on its rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 enable  input  1  advance enable; when low, all state holds and no handshakes complete.
REQ-004 cfg_load  input  1  pulse; latch cfg_base, cfg_stride, cfg_clip_w, cfg_clip_h, cfg_color.
REQ-005 cfg_base  input  20  frame-buffer base byte address.
REQ-006 cfg_stride  input  12  bytes per raster row, unsigned.
REQ-007 cfg_clip_w, cfg_clip_h  input  12 each  visible width/height, unsigned.
REQ-008 cfg_color  input  8  pixel value written (8 bpp).
REQ-009 pix_valid  input  1  driven by the line generator's pixel_data_rdy.
REQ-010 pix_x, pix_y  input  12 each  signed pixel coordinates.
REQ-011 pause  output  1  drives the line generator's ena_pause.
REQ-012 wr_req  output  1  memory write request.
REQ-013 wr_addr  output  20  write byte address.
REQ-014 wr_data  output  8  write byte.
REQ-015 wr_ack  input  1  memory accepted the current request.
REQ-016 idle  output  1  high when pipeline and FIFO are empty.
REQ-017 clip_cnt  output  16  count of discarded pixels, saturating.
REQ-018 Parameter FIFO_DEPTH, default 8, power of two >= 4.

Function
REQ-019 Pixel accepted on a clock edge when enable=1, pix_valid=1 and pause=0; pix_valid while pause=1 is ignored.
REQ-020 Stage S1 (1 cycle): clip test; pixel discarded if pix_x<0, pix_y<0, pix_x>=clip_w or pix_y>=clip_h (signed compare against zero-extended limits).
REQ-021 Discarded pixel increments clip_cnt by 1, saturating at 16'hFFFF; it never reaches the FIFO.
REQ-022 S1 computes y*stride as a 24-bit unsigned product; S2 (1 cycle) forms addr = base + product + x, truncated to 20 bits (wrap-around permitted).
REQ-023 Each entry carries the cfg_color latched at the time of acceptance.
REQ-024 S2 output pushed into the FIFO; accept-to-wr_req latency is 3 cycles with an empty FIFO.
REQ-025 pause = (fifo_count + s1_valid + s2_valid) >= FIFO_DEPTH, combinational from registered state only; FIFO never overflows.
REQ-026 wr_req = FIFO non-empty; wr_addr/wr_data show the FIFO head and stay stable until wr_ack.
REQ-027 Pop on clock edge with wr_req=1, wr_ack=1, enable=1; wr_ack without wr_req is ignored.
REQ-028 Simultaneous push and pop leaves fifo_count unchanged; push to a full FIFO with pop in the same cycle is permitted.
REQ-029 cfg_load applies on the next edge; pixels already accepted keep their original base/stride/color; clip for S1 uses registered cfg.
REQ-030 idle = !s1_valid && !s2_valid && fifo_count==0.

Reset
REQ-031 On reset_n low: pipeline valids, FIFO pointers/count, clip_cnt and all cfg registers cleared to 0; pause=0, wr_req=0, idle=1, wr_addr=0, wr_data=0.
REQ-032 Reset mid-operation discards all pending writes; no wr_req in the cycle following deassertion.
REQ-033 Reset deassertion is synchronised externally; no internal synchroniser.

Structure
REQ-034 Shared geo package holds ADDR_W=20, COORD_W=12, DATA_W=8 and typedef pix_wr_t {addr, data}.
REQ-035 FIFO is sub-module geo_wr_fifo (synchronous, parameterised depth, pix_wr_t payload, count output); remainder is in geo_pixel_writer.

Verification
REQ-036 cfg base=0x01000, stride=640, clip 640x480, color=0x5A; pixel (3,2), wr_ack tied 1 -> single write addr 0x01503, data 0x5A, 3 cycles after accept.
REQ-037 Pixels (-1,5), (640,0), (0,480) -> no wr_req, clip_cnt=3, idle returns to 1.
REQ-038 wr_ack held 0, pixel stream continuous -> pause rises when occupancy reaches 8; exactly 8 writes held; release ack -> 8 writes in order, one per cycle.
REQ-039 base=0xFFFF0, stride=0, pixel (0x20,0) -> wr_addr=0x00010 (wrap).
REQ-040 Assert reset_n low with 5 entries queued -> wr_req=0, idle=1 immediately; after release, no stale write.
REQ-041 cfg_load color=0x11 one cycle after accepting a pixel with color 0x5A -> that write carries 0x5A, next pixel 0x11.
